vmask_feed: RTL
===============

# vmask_feed

Mask-word sequencer placed directly upstream of the vector find-first-set stage (`vFirst`). It accepts one mask-reduction request carrying a vector length, a vector register file (VRF) source address and a destination address. It reads ceil(vl/REQ_DATA_WIDTH) mask words from the VRF, clears tail bits at or beyond vl, optionally ANDs each word with v0, and streams the words in order with a word index and an end flag. After each request it holds off new requests until the downstream pipeline has drained.

## Interface
- REQ_DATA_WIDTH, 64, mask word width; must equal 1<<DATA_WIDTH_BITS
- DATA_WIDTH_BITS, 6, log2 of word width
- IDX_BITS, 10, word-index width
- REQ_ADDR_WIDTH, 32, destination address width
- VRF_ADDR_WIDTH, 10, VRF word address width
- DRAIN_CYCLES, 6, hold-off after the last word issues
- clk  in  1  clock, all logic on posedge
- rst  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  block idle and drained
- req_vl  in  IDX_BITS+DATA_WIDTH_BITS+1  vector length in bits
- req_src  in  VRF_ADDR_WIDTH  first mask word address
- req_dst  in  REQ_ADDR_WIDTH  destination tag, passed through
- req_masked  in  1  AND each word with v0
- rd_en  out  1  VRF read strobe
- rd_addr  out  VRF_ADDR_WIDTH  VRF read address
- rd_data  in  REQ_DATA_WIDTH  mask word, valid the cycle after rd_en
- rd_v0_data  in  REQ_DATA_WIDTH  matching v0 word, same timing as rd_data
- out_m0  out  REQ_DATA_WIDTH  processed mask word
- out_valid  out  1  word strobe
- out_start_idx  out  IDX_BITS  word index, 0-based
- out_end  out  1  last word of the request
- out_addr  out  REQ_ADDR_WIDTH  latched req_dst

## Operation
- FSM has three states: IDLE, READ, DRAIN. Reset (rst=0 at a posedge) enters IDLE. On reset, all outputs are 0, and req_ready is 0 during the reset cycle.
- IDLE: req_ready=1. When req_valid&req_ready, the block latches vl, src, dst and masked.
  - nwords = (vl + REQ_DATA_WIDTH-1) >> DATA_WIDTH_BITS.
  - vl above 1<<(IDX_BITS+DATA_WIDTH_BITS) is clamped to that value.
  - Next state is READ.
- READ: asserts rd_en every cycle with rd_addr = src+k, for k = 0..nwords-1. Address wraps modulo 2^VRF_ADDR_WIDTH. After the last read, next state is DRAIN.
- vl=0: no reads are issued. One word issues with out_m0=0, out_start_idx=0, out_end=1. Next state is DRAIN.
- Word processing, in the cycle rd_data is valid:
  - word = rd_data, AND rd_v0_data when masked (see Configuration).
  - On the last word, when vl mod REQ_DATA_WIDTH = r ≠ 0, bits [REQ_DATA_WIDTH-1:r] are cleared.
  - The result is registered onto out_m0.
  - The registered outputs are out_valid=1, out_start_idx=k, out_end=(k==nwords-1), out_addr=dst.
- When out_valid=0, out_m0, out_start_idx, out_end and out_addr are 0.
- DRAIN: counts DRAIN_CYCLES cycles starting after the out_end cycle, then returns to IDLE. req_ready stays 0 throughout.
- There is no downstream backpressure. Words issue back-to-back, one per cycle.
- Reset mid-request: the request is abandoned and the block returns to IDLE with outputs 0. No further out_valid is produced for that request.

## Timing
- Request accepted at edge E0: rd_en is high in the cycle after E0, and the first out_valid occurs 2 cycles after the first rd_en.
- Issue rate: 1 word/cycle. N words give N consecutive out_valid cycles.
- req_ready first returns high exactly DRAIN_CYCLES+1 cycles after the out_end cycle.
- rd_data and rd_v0_data are sampled only in the cycle following a rd_en; they are ignored otherwise.

## Configuration
- VMASK_FEED_V0_EN defined: when req_masked=1, each word is ANDed with rd_v0_data.
- VMASK_FEED_V0_EN undefined: req_masked and rd_v0_data are ignored (ports stay present) and words pass unmasked apart from tail clearing.

## Test plan
- Full word: vl=64, src=0x10, rd_data=0xF0 -> one rd_en at addr 0x10, then out_m0=0xF0, idx 0, out_end=1, out_addr=req_dst.
- Tail clear: vl=70, word1 rd_data=all-ones -> two words; idx1 out_m0=0x3F with out_end=1, idx0 has out_end=0.
- v0 masking: VMASK_FEED_V0_EN defined, masked=1, rd_data=0xFF, v0=0x0F -> out_m0=0x0F. With the macro undefined -> out_m0=0xFF.
- vl=0 -> no rd_en, and a single out_valid with out_m0=0, out_end=1. req_ready returns high DRAIN_CYCLES+1 cycles later.
- Address wrap plus back-to-back: src=0x3FF, vl=192 -> rd_addr sequence 0x3FF, 0x000, 0x001. A second req_valid held high is accepted only after the drain completes.
- Reset mid-READ: rst=0 at the second read -> outputs 0 next cycle, no out_end, and req_ready=1 after rst releases.

Source files
------------

// File: rtl/vmask_feed.sv
// vmask_feed: mask-word sequencer feeding the vector find-first-set stage.
// Reads ceil(vl/REQ_DATA_WIDTH) mask words from the VRF and clears tail bits
// at or beyond vl. Each word is streamed out with its index and an end flag.
// After the last word the block holds off new requests for DRAIN_CYCLES
// cycles so the downstream pipeline can empty.
// Optional feature macro: VMASK_FEED_V0_EN. When it is defined, words of a
// masked request are ANDed with the matching v0 word.
// Requires DRAIN_CYCLES >= 1.
module vmask_feed #(
    parameter int REQ_DATA_WIDTH  = 64,
    parameter int DATA_WIDTH_BITS = 6,
    parameter int IDX_BITS        = 10,
    parameter int REQ_ADDR_WIDTH  = 32,
    parameter int VRF_ADDR_WIDTH  = 10,
    parameter int DRAIN_CYCLES    = 6
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                req_valid,
    output logic                                req_ready,
    input  logic [IDX_BITS+DATA_WIDTH_BITS:0]   req_vl,
    input  logic [VRF_ADDR_WIDTH-1:0]           req_src,
    input  logic [REQ_ADDR_WIDTH-1:0]           req_dst,
    input  logic                                req_masked,
    output logic                                rd_en,
    output logic [VRF_ADDR_WIDTH-1:0]           rd_addr,
    input  logic [REQ_DATA_WIDTH-1:0]           rd_data,
    input  logic [REQ_DATA_WIDTH-1:0]           rd_v0_data,
    output logic [REQ_DATA_WIDTH-1:0]           out_m0,
    output logic                                out_valid,
    output logic [IDX_BITS-1:0]                 out_start_idx,
    output logic                                out_end,
    output logic [REQ_ADDR_WIDTH-1:0]           out_addr
);

    localparam int VL_W = IDX_BITS + DATA_WIDTH_BITS + 1;
    localparam int NW_W = IDX_BITS + 1;
    localparam int DCW  = $clog2(DRAIN_CYCLES + 1);

    // Largest legal vector length; anything above it is clamped.
    localparam logic [VL_W-1:0] VL_MAX = {1'b1, {(VL_W-1){1'b0}}};

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_READ  = 2'd1;
    localparam logic [1:0] S_DRAIN = 2'd2;

    logic [1:0]                 state;
    logic [VL_W-1:0]            vl_c;
    logic [NW_W-1:0]            nwords_in;
    logic [NW_W-1:0]            nwords_q;
    logic [DATA_WIDTH_BITS-1:0] rem_q;
    logic [VRF_ADDR_WIDTH-1:0]  src_q;
    logic [REQ_ADDR_WIDTH-1:0]  dst_q;
    logic                       masked_q;
    logic [IDX_BITS-1:0]        rd_idx;
    logic                       rd_last;
    logic [DCW-1:0]             drain_cnt;
    logic                       accept;
    logic                       zero_issue;

    // Read-data stage: marks the cycle in which rd_data belongs to us.
    logic                       rd_pend;
    logic [IDX_BITS-1:0]        p_idx;
    logic                       p_last;

    logic [REQ_DATA_WIDTH-1:0]  v0_term;
    logic [REQ_DATA_WIDTH-1:0]  tail_keep;
    logic [REQ_DATA_WIDTH-1:0]  word;

    assign vl_c      = (req_vl > VL_MAX) ? VL_MAX : req_vl;
    // Ceiling divide without a wide adder: whole words plus one for any remainder.
    assign nwords_in = vl_c[VL_W-1:DATA_WIDTH_BITS]
                     + NW_W'(|vl_c[DATA_WIDTH_BITS-1:0]);

    // Ready is gated by rst so it reads 0 during the reset cycle itself.
    assign req_ready  = rst & (state == S_IDLE);
    assign accept     = req_valid & req_ready;
    assign zero_issue = accept & (nwords_in == '0);

    assign rd_en   = (state == S_READ);
    assign rd_addr = src_q + VRF_ADDR_WIDTH'(rd_idx);
    assign rd_last = ({1'b0, rd_idx} == (nwords_q - NW_W'(1)));

`ifdef VMASK_FEED_V0_EN
    assign v0_term = masked_q ? rd_v0_data : '1;
`else
    // The v0 path is compiled out; the ports are kept so both builds share a footprint.
    logic v0_unused;
    assign v0_term   = '1;
    assign v0_unused = ^{masked_q, rd_v0_data};
`endif

    // Only the final word of a request with a partial last word loses its upper bits.
    assign tail_keep = (p_last && (rem_q != '0)) ? ~({REQ_DATA_WIDTH{1'b1}} << rem_q) : '1;
    assign word      = rd_data & v0_term & tail_keep;

    // Control FSM: request capture, read sequencing and post-request drain.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= S_IDLE;
            nwords_q  <= '0;
            rem_q     <= '0;
            src_q     <= '0;
            dst_q     <= '0;
            masked_q  <= 1'b0;
            rd_idx    <= '0;
            drain_cnt <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        nwords_q  <= nwords_in;
                        rem_q     <= vl_c[DATA_WIDTH_BITS-1:0];
                        src_q     <= req_src;
                        dst_q     <= req_dst;
                        masked_q  <= req_masked;
                        rd_idx    <= '0;
                        drain_cnt <= '0;
                        // vl=0 issues its single empty word directly and skips reading.
                        state     <= (nwords_in == '0) ? S_DRAIN : S_READ;
                    end
                end
                S_READ: begin
                    rd_idx <= rd_idx + IDX_BITS'(1);
                    if (rd_last) state <= S_DRAIN;
                end
                S_DRAIN: begin
                    // The hold-off is counted from the cycle in which out_end is visible.
                    if (out_end)
                        drain_cnt <= DCW'(1);
                    else if (drain_cnt != '0)
                        drain_cnt <= drain_cnt + DCW'(1);
                    if (drain_cnt == DCW'(DRAIN_CYCLES)) state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Datapath: tag the returning read, then register the processed word.
    always_ff @(posedge clk) begin
        if (!rst) begin
            rd_pend       <= 1'b0;
            p_idx         <= '0;
            p_last        <= 1'b0;
            out_valid     <= 1'b0;
            out_m0        <= '0;
            out_start_idx <= '0;
            out_end       <= 1'b0;
            out_addr      <= '0;
        end else begin
            rd_pend       <= rd_en;
            p_idx         <= rd_idx;
            p_last        <= rd_en & rd_last;
            out_valid     <= rd_pend | zero_issue;
            out_m0        <= rd_pend ? word : '0;
            out_start_idx <= rd_pend ? p_idx : '0;
            out_end       <= rd_pend ? p_last : zero_issue;
            out_addr      <= rd_pend ? dst_q : (zero_issue ? req_dst : '0);
        end
    end

endmodule
